// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 pattern blocks: FSM state encoding,
// data widths and a colour-dimming helper.
package ws2812_pkg;

    localparam int RGB_W     = 24;
    localparam int LED_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Quarter brightness: each 8-bit channel shifted right by two.
    function automatic logic [RGB_W-1:0] quarter(input logic [RGB_W-1:0] c);
        return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
    endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// Frame-interval timer. A start pulse clears the count and arms the timer;
// tick_done is high for the single cycle in which the count reaches
// FRAME_TICKS-1, after which the timer disarms until the next start.
module ws2812_frame_timer #(
    parameter int FRAME_TICKS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic tick_done
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [CNT_W-1:0] cnt;
    logic             armed;

    assign tick_done = armed && (cnt == CNT_W'(FRAME_TICKS - 1));

    // Counter: restart on start, count while armed, stop after the last tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (armed) begin
            if (tick_done) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812_chase.sv
// Single-LED chase animation feeding a ws2812 string driver.
// Each frame waits FRAME_TICKS cycles, then writes every LED in ascending
// order (one write strobe every second cycle). The LED at 'pos' gets the
// colour latched at frame start, all others 0; 'pos' advances each frame.
// Optional feature macro: CHASE_TAIL_EN adds a quarter-brightness tail LED
// just behind 'pos'.
//
// Handshake: write is a valid-only strobe (no ready). led_num/rgb_data are
// valid exactly in the cycle write=1 and the downstream driver must accept
// it then; between strobes they hold their last value.
module ws2812_chase
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int FRAME_TICKS = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [RGB_W-1:0]     color,
    output logic [LED_IDX_W-1:0] led_num,
    output logic [RGB_W-1:0]     rgb_data,
    output logic                 write,
    output logic                 frame_done,
    output state_e               state_dbg
);

    localparam logic [LED_IDX_W-1:0] LAST_IDX = LED_IDX_W'(NUM_LEDS - 1);

    state_e               state, next_state;
    logic [LED_IDX_W-1:0] index, next_index;
    logic [LED_IDX_W-1:0] pos, next_pos;
    logic [RGB_W-1:0]     frame_col, next_col;
    logic                 timer_start;
    logic                 tick_done;
    logic                 last_led;
    logic                 write_d;
    logic                 frame_done_d;
    logic [RGB_W-1:0]     rgb_d;

    assign last_led  = (index == LAST_IDX);
    assign state_dbg = state;

    ws2812_frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (timer_start),
        .tick_done(tick_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame datapath registers: LED index, chase position, latched colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index     <= '0;
            pos       <= '0;
            frame_col <= '0;
        end else begin
            index     <= next_index;
            pos       <= next_pos;
            frame_col <= next_col;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        next_state  = state;
        next_index  = index;
        next_pos    = pos;
        next_col    = frame_col;
        timer_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    next_state  = ST_WAIT;
                    timer_start = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (tick_done) begin
                    next_state = ST_WRITE;
                    next_index = '0;
                    next_col   = color;
                end
            end
            ST_WRITE: begin
                next_state = ST_GAP;
            end
            ST_GAP: begin
                if (!last_led) begin
                    next_index = index + 8'd1;
                    next_state = ST_WRITE;
                end else begin
                    next_pos = (pos == LAST_IDX) ? '0 : pos + 8'd1;
                    if (enable) begin
                        next_state  = ST_WAIT;
                        timer_start = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode, computed from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        write_d      = (next_state == ST_WRITE);
        frame_done_d = (next_state == ST_GAP) && (next_index == LAST_IDX);
        rgb_d        = '0;
        if (next_index == pos) begin
            rgb_d = next_col;
        end
`ifdef CHASE_TAIL_EN
        if ((NUM_LEDS > 1) &&
            (next_index == ((pos == '0) ? LAST_IDX : pos - 8'd1))) begin
            rgb_d = quarter(next_col);
        end
`endif
    end

    // Registered outputs; LED data only loads on a write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_num    <= '0;
            rgb_data   <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            write      <= write_d;
            frame_done <= frame_done_d;
            if (write_d) begin
                led_num  <= next_index;
                rgb_data <= rgb_d;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_chase.sv
// Self-checking bench for ws2812_chase. A frame-level reference model
// (which LED is lit for a given position and colour) predicts every write.
module tb_ws2812_chase;
    import ws2812_pkg::*;

    localparam int N   = 4;
    localparam int FT  = 20;
    localparam int TMO = 3 * FT + 4 * N + 10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] color = '0;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        write;
    logic        frame_done;
    state_e      state_dbg;

    always #5 clk = ~clk;

    ws2812_chase #(
        .NUM_LEDS   (N),
        .FRAME_TICKS(FT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .color     (color),
        .led_num   (led_num),
        .rgb_data  (rgb_data),
        .write     (write),
        .frame_done(frame_done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    int            write_cnt = 0;
    int            model_pos = 0;
    logic [31:0]   obs_q[$];
    logic [31:0]   exp_q[$];
    logic [2*N-1:0] wr_pat, fd_pat;

    always @(negedge clk) if (write === 1'b1) write_cnt++;

    // Reference model: contents expected for LED i in a frame at position p.
    function automatic logic [31:0] exp_word(input int i, input logic [23:0] col, input int p);
        logic [23:0] v;
        v = (i == p) ? col : 24'h000000;
`ifdef CHASE_TAIL_EN
        if (N > 1 && i == (p + N - 1) % N)
            v = {col[23:16] >> 2, col[15:8] >> 2, col[7:0] >> 2};
`endif
        return {8'(i), v};
    endfunction

    function automatic logic [2*N-1:0] exp_wr_pat();
        logic [2*N-1:0] r;
        for (int c = 0; c < 2 * N; c++) r[c] = (c % 2 == 0);
        return r;
    endfunction

    function automatic logic [2*N-1:0] exp_fd_pat();
        logic [2*N-1:0] r;
        r = '0;
        r[2*N-1] = 1'b1;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Wait for the first write of a frame, then record 2*N cycles of
    // outputs. Optionally change colour / drop enable right after write k.
    task automatic collect_frame(input int chg_idx, input logic [23:0] chg_col,
                                 input int drop_idx, output bit to);
        int w;
        to = 1'b0;
        obs_q.delete();
        wr_pat = '0;
        fd_pat = '0;
        w = 0;
        while (write !== 1'b1 && w < TMO) begin
            @(negedge clk);
            w++;
        end
        if (write !== 1'b1) begin
            to = 1'b1;
            return;
        end
        for (int c = 0; c < 2 * N; c++) begin
            wr_pat[c] = write;
            fd_pat[c] = frame_done;
            if (write === 1'b1) obs_q.push_back({led_num, rgb_data});
            if (c == 2 * chg_idx) color = chg_col;
            if (c == 2 * drop_idx) enable = 1'b0;
            if (c < 2 * N - 1) @(negedge clk);
        end
    endtask

    task automatic build_exp(input logic [23:0] col);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i, col, model_pos));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        color = 24'hABCDEF;
        repeat (3) @(negedge clk);
        n_cmp++; if (led_num !== 8'd0) begin n_bad++; $display("FAIL reset_led_num got %h want 00", led_num); end
        n_cmp++; if (rgb_data !== 24'd0) begin n_bad++; $display("FAIL reset_rgb got %h want 000000", rgb_data); end
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write got %b want 0", write); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
        enable = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (state_dbg !== ST_IDLE || write !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold state %0d write %b want IDLE/0", state_dbg, write); end
    endtask

    task automatic test_first_frame();
        bit to;
        reset = 1'b0;
        @(negedge clk);
        color = 24'h000010;
        enable = 1'b1;
        model_pos = 0;
        @(negedge clk);
        reset = 1'b1;
        collect_frame(-1, 24'h0, -1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL first_frame_timeout got no write want write"); end
        n_cmp++; if (wr_pat !== exp_wr_pat()) begin n_bad++; $display("FAIL first_frame_write_pattern got %b want %b", wr_pat, exp_wr_pat()); end
        n_cmp++; if (fd_pat !== exp_fd_pat()) begin n_bad++; $display("FAIL first_frame_done_pattern got %b want %b", fd_pat, exp_fd_pat()); end
        build_exp(24'h000010);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL first_frame_led%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
            end
        end
        model_pos = (model_pos + 1) % N;
    endtask

    task automatic test_chase_wrap();
        bit to;
        int base, lit;
        logic [23:0] col;
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        model_pos = 0;
        col = 24'($urandom) | 24'h000001;
        color = col;
        base = write_cnt;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            collect_frame(-1, 24'h0, -1, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL wrap_timeout frame %0d got no write want write", k); end
            build_exp(col);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL wrap_f%0d_led%0d got %h want %h", k, i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
                end
            end
            lit = -1;
            foreach (obs_q[i]) if (obs_q[i][23:0] === col) lit = i;
            n_cmp++; if (lit != k % N) begin n_bad++; $display("FAIL wrap_lit_index frame %0d got %0d want %0d", k, lit, k % N); end
            model_pos = (model_pos + 1) % N;
            col = 24'($urandom) | 24'h000001;
            color = col;
        end
        n_cmp++; if (write_cnt - base != 5 * N) begin n_bad++; $display("FAIL wrap_write_count got %0d want %0d", write_cnt - base, 5 * N); end
    endtask

    task automatic test_color_change();
        bit to;
        color = 24'h000010;
        collect_frame(1, 24'h100000, -1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL colchg_timeout got no write want write"); end
        build_exp(24'h000010);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL colchg_old_led%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
            end
        end
        model_pos = (model_pos + 1) % N;
        collect_frame(-1, 24'h0, -1, to);
        build_exp(24'h100000);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL colchg_new_led%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
            end
        end
        model_pos = (model_pos + 1) % N;
    endtask

    task automatic test_enable_drop();
        bit to;
        int base;
        logic [23:0] col;
        // Previous frame just ended in its last gap; next cycle is WAIT.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL drop_wait_state got %0d want IDLE", state_dbg); end
        base = write_cnt;
        repeat (3 * FT) @(negedge clk);
        n_cmp++; if (write_cnt != base) begin n_bad++; $display("FAIL drop_wait_writes got %0d want 0", write_cnt - base); end
        // Re-enable, then drop enable during the first write.
        col = 24'($urandom);
        color = col;
        enable = 1'b1;
        collect_frame(-1, 24'h0, 0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL drop_write_timeout got no write want write"); end
        n_cmp++; if (wr_pat !== exp_wr_pat()) begin n_bad++; $display("FAIL drop_write_pattern got %b want %b", wr_pat, exp_wr_pat()); end
        build_exp(col);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL drop_write_led%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
            end
        end
        model_pos = (model_pos + 1) % N;
        @(negedge clk);
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL drop_write_state got %0d want IDLE", state_dbg); end
        base = write_cnt;
        repeat (2 * FT) @(negedge clk);
        n_cmp++; if (write_cnt != base) begin n_bad++; $display("FAIL drop_write_idle_writes got %0d want 0", write_cnt - base); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int w;
        logic [23:0] col;
        col = 24'($urandom);
        color = col;
        enable = 1'b1;
        w = 0;
        while (!(write === 1'b1 && led_num === 8'd2) && w < 2 * TMO) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (!(write === 1'b1 && led_num === 8'd2)) begin n_bad++; $display("FAIL rst_mid_wait got no third write want write idx 2"); end
        reset = 1'b0;
        #1;
        n_cmp++; if (write !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_strobes got write %b done %b want 0 0", write, frame_done); end
        n_cmp++; if (led_num !== 8'd0 || rgb_data !== 24'd0) begin
            n_bad++; $display("FAIL rst_mid_data got %h/%h want 00/000000", led_num, rgb_data); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_mid_state got %0d want IDLE", state_dbg); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_pos = 0;
        collect_frame(-1, 24'h0, -1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL rst_mid_restart_timeout got no write want write"); end
        build_exp(col);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL rst_mid_led%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
            end
        end
        model_pos = (model_pos + 1) % N;
    endtask

    task automatic test_random_frames();
        bit to;
        logic [23:0] col;
        int chg;
        for (int k = 0; k < 6; k++) begin
            col = 24'($urandom);
            color = col;
            chg = $urandom_range(N - 1, 0);
            collect_frame(chg, 24'($urandom), -1, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rand_timeout frame %0d got no write want write", k); end
            n_cmp++; if (fd_pat !== exp_fd_pat()) begin n_bad++; $display("FAIL rand_done_pattern frame %0d got %b want %b", k, fd_pat, exp_fd_pat()); end
            build_exp(col);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL rand_f%0d_led%0d got %h want %h", k, i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
                end
            end
            model_pos = (model_pos + 1) % N;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_frame();
        test_chase_wrap();
        test_color_change();
        test_enable_drop();
        test_reset_mid_frame();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_chase.md
WS2812_CHASE -- requirements
Module: ws2812_chase

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of LEDs in the string (1..255).
REQ-002 SHALL have parameter FRAME_TICKS, default 1000, clk cycles between animation frames (>=2*NUM_LEDS+2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high runs the animation; low parks in IDLE after the current frame.
REQ-006 SHALL have port color  input  24  colour of the lit LED, sampled at frame start.
REQ-007 SHALL have port led_num  output  8  LED index presented to the downstream ws2812 driver.
REQ-008 SHALL have port rgb_data  output  24  colour for led_num.
REQ-009 SHALL have port write  output  1  one-cycle strobe; led_num/rgb_data valid while high.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last write of a frame.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, WRITE, GAP.
REQ-012 IDLE SHALL go to WAIT when enable=1, clearing the tick counter.
REQ-013 WAIT SHALL count 0..FRAME_TICKS-1, then go to WRITE with index=0 and latch color into a frame register.
REQ-014 WRITE SHALL assert write for exactly one cycle with led_num=index, then go to GAP.
REQ-015 GAP SHALL hold write=0 for one cycle; if index<NUM_LEDS-1, increment index and return to WRITE, else pulse frame_done and go to WAIT (enable=1) or IDLE (enable=0).
REQ-016 Writes SHALL therefore occur every second cycle, NUM_LEDS writes per frame, led_num 0..NUM_LEDS-1 ascending.
REQ-017 rgb_data SHALL be the latched colour when index==pos, else 24'h000000.
REQ-018 pos SHALL advance by 1 at each frame_done, wrapping NUM_LEDS-1 -> 0.
REQ-019 color changes mid-frame SHALL NOT affect the frame in progress.
REQ-020 enable falling mid-frame SHALL let the frame complete; enable falling in WAIT SHALL return to IDLE next cycle without writes.
REQ-021 With NUM_LEDS=1, pos SHALL stay 0 and every frame writes index 0 with the colour.
REQ-022 led_num and rgb_data SHALL be registered outputs; they may hold stale values while write=0.

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, index=0, pos=0, tick counter=0, frame colour=0.
REQ-024 During reset, outputs SHALL be led_num=0, rgb_data=0, write=0, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no further write; on release, operation restarts from IDLE.

Configuration
REQ-026 Macro CHASE_TAIL_EN SHALL, when defined, give LED (pos-1 mod NUM_LEDS) each channel of the latched colour shifted right by 2 (quarter brightness) when NUM_LEDS>1.
REQ-027 Without CHASE_TAIL_EN, only the pos LED SHALL be non-zero; all other LEDs SHALL be written 0.

Structure
REQ-028 Package ws2812_pkg SHALL hold the FSM state encoding, RGB_W=24, LED_IDX_W=8 constants.
REQ-029 The frame-interval counter SHALL be sub-module ws2812_frame_timer (clk, reset, start, tick_done), reusable by other pattern blocks.
REQ-030 Outputs SHALL connect directly to ws2812 led_num, rgb_data and write with no glue logic.

Verification
REQ-031 NUM_LEDS=4, FRAME_TICKS=20, color=24'h000010, enable=1 from reset release -> first frame writes idx0=000010, idx1..3=000000, write high 1 cycle every 2 cycles, frame_done after 4th write.
REQ-032 Run 5 frames -> lit index sequence 0,1,2,3,0 (wrap), exactly 20 write strobes.
REQ-033 Change color to 24'h100000 during frame-2 writes -> frame 2 unchanged, frame 3 uses 100000.
REQ-034 Drop enable during WAIT -> IDLE next cycle, zero writes; drop during WRITE -> frame finishes, then IDLE.
REQ-035 Assert reset during the 3rd write of a frame -> write=0 and all outputs 0 within the same cycle; after release with enable=1, next frame restarts at pos=0.
REQ-036 With CHASE_TAIL_EN, color=24'h404040, pos=2 -> idx1=101010, idx2=404040, idx0 and idx3=000000.
